// File: rtl/nios_key_ctrl_pkg.sv
// Shared constants and types for the debounced key/switch controller.
package nios_key_ctrl_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_EDGE_SEL = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_COUNT  = 1'b1
    } db_state_e;

endpackage

// File: rtl/nios_system_key_ctrl_if.sv
// Avalon-MM slave signal bundle for the key controller register port.
interface nios_system_key_ctrl_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read, write, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read, write, writedata,
        output readdata
    );

endinterface

// File: rtl/nios_key_debounce.sv
// One input bit: two-flop synchroniser, STABLE/COUNT debounce FSM, debounced
// value and its one-cycle-delayed copy for edge detection.
module nios_key_debounce
    import nios_key_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_pin,
    output logic o_db,
    output logic o_db_d
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    db_state_e        r_state;
    db_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_db;
    logic             w_db_nxt;
    logic             r_db_d;

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_state <= ST_STABLE;
            r_cnt   <= '0;
            r_db    <= 1'b0;
            r_db_d  <= 1'b0;
        end else begin
            r_sync1 <= i_pin;
            r_sync2 <= r_sync1;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_db    <= w_db_nxt;
            r_db_d  <= r_db;
        end
    end

    // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_db_nxt    = r_db;
        unique case (r_state)
            ST_STABLE: begin
                w_cnt_nxt = '0;
                if (r_sync2 != r_db) begin
                    w_state_nxt = ST_COUNT;
                    w_cnt_nxt   = CNT_W'(1);
                end
            end
            ST_COUNT: begin
                if (r_sync2 == r_db) begin
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_db_nxt    = r_sync2;
                    w_state_nxt = ST_STABLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_STABLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_db   = r_db;
    assign o_db_d = r_db_d;

endmodule

// File: rtl/nios_system_key_ctrl.sv
// Debounced, edge-capturing, interrupt-capable input controller: register file,
// W1C capture logic and registered read mux around WIDTH debounce slices.
module nios_system_key_ctrl
    import nios_key_ctrl_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                   clk,
    input  logic                   reset,
    nios_system_key_ctrl_if.slave  bus,
    input  logic [WIDTH-1:0]       in_port,
    output logic                   irq
);

    logic [WIDTH-1:0] w_db;
    logic [WIDTH-1:0] w_db_d;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic             w_wr;
    logic [31:0]      w_rd_mux;
    logic             w_unused;

    logic [WIDTH-1:0] r_edge_sel;
    logic [WIDTH-1:0] r_irq_mask;
    logic [WIDTH-1:0] r_edge_cap;
    logic [31:0]      r_readdata;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        nios_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk    (clk),
            .reset  (reset),
            .i_pin  (in_port[i]),
            .o_db   (w_db[i]),
            .o_db_d (w_db_d[i])
        );
    end

    assign w_rise = w_db & ~w_db_d;
    assign w_fall = ~w_db & w_db_d;
    assign w_edge = (r_edge_sel & w_fall) | (~r_edge_sel & w_rise);

    assign w_wr  = bus.chipselect & bus.write;
    assign w_clr = (w_wr && (bus.address == ADDR_EDGE_CAP)) ? bus.writedata[WIDTH-1:0] : '0;

    // Reads have no side effects, so the strobe is not needed by the data path.
    assign w_unused = bus.read ^ (^bus.writedata);

    always_comb begin
        w_rd_mux = '0;
        unique case (bus.address)
            ADDR_DATA:     w_rd_mux = 32'(w_db);
            ADDR_EDGE_SEL: w_rd_mux = 32'(r_edge_sel);
            ADDR_IRQ_MASK: w_rd_mux = 32'(r_irq_mask);
            ADDR_EDGE_CAP: w_rd_mux = 32'(r_edge_cap);
            default:       w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_edge_sel <= '0;
            r_irq_mask <= '0;
            r_edge_cap <= '0;
            r_readdata <= '0;
        end else begin
            if (w_wr && (bus.address == ADDR_EDGE_SEL)) r_edge_sel <= bus.writedata[WIDTH-1:0];
            if (w_wr && (bus.address == ADDR_IRQ_MASK)) r_irq_mask <= bus.writedata[WIDTH-1:0];
            // A new edge wins over a simultaneous write-1-to-clear of the same bit.
            r_edge_cap <= (r_edge_cap & ~w_clr) | w_edge;
            r_readdata <= w_rd_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = |(r_edge_cap & r_irq_mask);

endmodule

// File: tb/tb_nios_system_key_ctrl.sv
// Directed self-checking bench: register reads go through an expected-value
// scoreboard, irq is checked directly at the cycle boundaries that matter.
module tb_nios_system_key_ctrl;

    localparam int WIDTH = 4;
    localparam int DEB   = 4;

    typedef struct {
        string       tag;
        logic [31:0] value;
    } exp_t;

    logic             clk;
    logic             reset;
    logic [WIDTH-1:0] in_port;
    logic             irq;

    int   errors;
    int   checks;
    exp_t sb_q[$];

    nios_system_key_ctrl_if bus ();

    nios_system_key_ctrl #(
        .WIDTH           (WIDTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .in_port (in_port),
        .irq     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
        bus.address    = addr;
        bus.writedata  = data;
        bus.chipselect = 1'b1;
        bus.write      = 1'b1;
        cyc(1);
        bus.chipselect = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;
    endtask

    task automatic bus_read(input logic [1:0] addr, input string tag, input logic [31:0] exp);
        exp_t e;
        sb_q.push_back('{tag: tag, value: exp});
        bus.address    = addr;
        bus.chipselect = 1'b1;
        bus.read       = 1'b1;
        cyc(1);
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        e = sb_q.pop_front();
        check(e.tag, bus.readdata, e.value);
    endtask

    initial begin
        errors         = 0;
        checks         = 0;
        reset          = 1'b1;
        in_port        = '0;
        bus.address    = '0;
        bus.chipselect = 1'b0;
        bus.read       = 1'b0;
        bus.write      = 1'b0;
        bus.writedata  = '0;

        // Reset
        cyc(3);
        reset = 1'b0;
        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        for (int a = 0; a < 4; a++) bus_read(2'(a), $sformatf("rst_rd%0d", a), 32'h0);

        // Upper bits ignore writes
        bus_write(2'd2, 32'hFFFF_FFFF);
        bus_read(2'd2, "mask_readback", 32'h0000_000F);

        // Clean press on bit 0 at edge T
        in_port[0] = 1'b1;
        cyc(5);
        bus_read(2'd0, "press_data_early", 32'h0);
        check("press_irq_T5", 32'(irq), 32'h0);
        cyc(1);
        check("press_irq_T6", 32'(irq), 32'h1);
        bus_read(2'd0, "press_data", 32'h1);
        bus_read(2'd3, "press_cap", 32'h1);
        bus_write(2'd3, 32'h1);
        check("w1c_irq_drop", 32'(irq), 32'h0);

        // Release bit 0: falling edge not selected
        in_port[0] = 1'b0;
        cyc(10);
        bus_read(2'd3, "release_nocap", 32'h0);

        // Bounce on bit 1
        for (int k = 0; k < 4; k++) begin
            in_port[1] = ~k[0];
            cyc(2);
        end
        cyc(10);
        check("bounce_irq", 32'(irq), 32'h0);
        bus_read(2'd0, "bounce_data", 32'h0);
        bus_read(2'd3, "bounce_cap", 32'h0);

        // Falling-edge select on bit 2, interrupt masked off
        bus_write(2'd1, 32'h4);
        bus_write(2'd2, 32'h0);
        in_port[2] = 1'b1;
        cyc(10);
        bus_read(2'd0, "fall_data_pressed", 32'h4);
        bus_read(2'd3, "fall_cap_pressed", 32'h0);
        in_port[2] = 1'b0;
        cyc(10);
        bus_read(2'd3, "fall_cap_released", 32'h4);
        bus_read(2'd0, "fall_data_released", 32'h0);
        check("fall_irq_masked", 32'(irq), 32'h0);
        bus_write(2'd3, 32'hF);
        bus_write(2'd1, 32'h0);
        bus_write(2'd2, 32'hF);
        bus_read(2'd3, "fall_cap_cleared", 32'h0);

        // W1C race: clear and new edge on bit 0 in the same cycle
        in_port[0] = 1'b1;
        cyc(10);
        in_port[0] = 1'b0;
        cyc(10);
        check("race_pending_irq", 32'(irq), 32'h1);
        in_port[0] = 1'b1;
        cyc(6);
        bus_write(2'd3, 32'h1);
        check("race_irq", 32'(irq), 32'h1);
        bus_read(2'd3, "race_cap", 32'h1);
        in_port[0] = 1'b0;
        cyc(10);
        bus_write(2'd3, 32'hF);
        check("race_cleared_irq", 32'(irq), 32'h0);

        // Reset two cycles into COUNT on bit 3
        in_port[3] = 1'b1;
        cyc(4);
        reset      = 1'b1;
        in_port[3] = 1'b0;
        cyc(2);
        reset = 1'b0;
        cyc(12);
        bus_read(2'd0, "rstmid_data", 32'h0);
        bus_read(2'd3, "rstmid_cap", 32'h0);
        bus_read(2'd2, "rstmid_mask", 32'h0);
        check("rstmid_irq", 32'(irq), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
